// File: rtl/watch_dp.sv
// watch_dp: HH:MM:SS.CC timekeeping datapath for the watch mode.
// A divided timebase advances centiseconds; carries ripple combinationally
// through sec/min/hour and every field registers on the same edge. Adjust
// pulses add one to their own field without producing a carry.
module watch_dp #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned INIT_HOUR = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_hour,
  input  logic       i_min,
  input  logic       i_sec,
  output logic [6:0] o_cs,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_tick
);

  localparam int unsigned      DIV      = CLK_FREQ / TICK_HZ;
  localparam int unsigned      DIV_W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [4:0]       HOUR_RST = 5'(INIT_HOUR % 24);

  logic [DIV_W-1:0] div_q, div_d;
  logic [6:0]       cs_q, cs_d;
  logic [5:0]       sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [4:0]       hour_q, hour_d;
  logic             tick_q;

  logic             tick;
  logic             c_cs, c_sec, c_min;
  logic [6:0]       sec_sum;
  logic [6:0]       min_sum;
  logic [5:0]       hour_sum;

  // Timebase divider and rollover carry chain, all from current state
  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DIV_W'(1);
    c_cs  = tick  & (cs_q  == 7'd99);
    c_sec = c_cs  & (sec_q == 6'd59);
    c_min = c_sec & (min_q == 6'd59);
  end

  // Field next-state: own carry plus adjust pulse, at most +2, one wrap step
  always_comb begin
    cs_d = cs_q;
    if (tick) begin
      cs_d = (cs_q == 7'd99) ? '0 : cs_q + 7'd1;
    end

    sec_sum = {1'b0, sec_q} + 7'(c_cs) + 7'(i_sec);
    sec_d   = (sec_sum >= 7'd60) ? sec_sum[5:0] - 6'd60 : sec_sum[5:0];

    min_sum = {1'b0, min_q} + 7'(c_sec) + 7'(i_min);
    min_d   = (min_sum >= 7'd60) ? min_sum[5:0] - 6'd60 : min_sum[5:0];

    hour_sum = {1'b0, hour_q} + 6'(c_min) + 6'(i_hour);
    hour_d   = (hour_sum >= 6'd24) ? hour_sum[4:0] - 5'd24 : hour_sum[4:0];
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      cs_q   <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= HOUR_RST;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cs_q   <= cs_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      tick_q <= tick;
    end
  end

  assign o_cs   = cs_q;
  assign o_sec  = sec_q;
  assign o_min  = min_q;
  assign o_hour = hour_q;
  assign o_tick = tick_q;

endmodule

// File: tb/tb_watch_dp.sv
// tb_watch_dp: directed + random bench for watch_dp against a reference
// that keeps time as a single centisecond-of-day count.
module tb_watch_dp;

  localparam int unsigned CLK_FREQ = 1000;
  localparam int unsigned TICK_HZ  = 100;
  localparam int          DIV      = 10;
  localparam int          DAY      = 24 * 60 * 60 * 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_hour = 1'b0;
  logic       i_min  = 1'b0;
  logic       i_sec  = 1'b0;
  logic [6:0] o_cs;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_tick;

  watch_dp #(
    .CLK_FREQ (CLK_FREQ),
    .TICK_HZ  (TICK_HZ),
    .INIT_HOUR(12)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .i_hour(i_hour),
    .i_min (i_min),
    .i_sec (i_sec),
    .o_cs  (o_cs),
    .o_sec (o_sec),
    .o_min (o_min),
    .o_hour(o_hour),
    .o_tick(o_tick)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: time of day in centiseconds, cycles since last tick
  int m_t;
  int m_phase;
  bit m_tick;

  function automatic int f_h(int t); return t / 360000;        endfunction
  function automatic int f_m(int t); return (t / 6000) % 60;   endfunction
  function automatic int f_s(int t); return (t / 100) % 60;    endfunction
  function automatic int f_c(int t); return t % 100;           endfunction

  task automatic model_reset();
    m_t     = 12 * 360000;
    m_phase = 0;
    m_tick  = 1'b0;
  endtask

  task automatic model_clock(bit ih, bit im, bit is);
    int h, m, s, c;
    bit tk;
    if (!rst) begin
      model_reset();
      return;
    end
    tk      = (m_phase == DIV - 1);
    m_phase = tk ? 0 : m_phase + 1;
    if (tk) m_t = (m_t + 1) % DAY;
    h = f_h(m_t); m = f_m(m_t); s = f_s(m_t); c = f_c(m_t);
    s = (s + int'(is)) % 60;
    m = (m + int'(im)) % 60;
    h = (h + int'(ih)) % 24;
    m_t    = ((h * 60 + m) * 60 + s) * 100 + c;
    m_tick = tk;
  endtask

  task automatic chk(string tag, logic [31:0] obs, int exp);
    n_assert++;
    assert (obs === 32'(exp))
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".cs"},   o_cs,   f_c(m_t));
    chk({tag, ".sec"},  o_sec,  f_s(m_t));
    chk({tag, ".min"},  o_min,  f_m(m_t));
    chk({tag, ".hour"}, o_hour, f_h(m_t));
    chk({tag, ".tick"}, o_tick, int'(m_tick));
  endtask

  task automatic step(string tag, bit ih, bit im, bit is);
    i_hour = ih;
    i_min  = im;
    i_sec  = is;
    @(posedge clk);
    model_clock(ih, im, is);
    #1;
    i_hour = 1'b0;
    i_min  = 1'b0;
    i_sec  = 1'b0;
    chk_all(tag);
  endtask

  task automatic first_tick(string tag);
    int k;
    k = 0;
    do begin
      step(tag, 1'b0, 1'b0, 1'b0);
      k++;
    end while (o_tick !== 1'b1 && k < 20);
    chk({tag, ".latency"}, k, 10);
    chk({tag, ".cs1"}, o_cs, 1);
  endtask

  initial begin
    int hs, ss, last, gap_cnt;
    model_reset();

    // 1: reset values, then first tick latency
    repeat (3) step("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.hour12", o_hour, 12);
    rst = 1'b1;
    first_tick("release");

    // 2: set 23:59:59 and roll over the whole day on one tick
    repeat (11) step("adj_h", 1'b1, 1'b0, 1'b0);
    repeat (59) step("adj_m", 1'b0, 1'b1, 1'b0);
    repeat (59) step("adj_s", 1'b0, 1'b0, 1'b1);
    chk("set.hour", o_hour, 23);
    chk("set.min",  o_min,  59);
    chk("set.sec",  o_sec,  59);
    for (int g = 0; g < 3000 && !(f_c(m_t) == 99 && m_phase == DIV - 1); g++)
      step("run99", 1'b0, 1'b0, 1'b0);
    step("dayroll", 1'b0, 1'b0, 1'b0);
    chk("dayroll.hour", o_hour, 0);
    chk("dayroll.min",  o_min,  0);
    chk("dayroll.sec",  o_sec,  0);
    chk("dayroll.cs",   o_cs,   0);

    // 3: minute adjust wraps 59 -> 0 without touching hour or sec
    for (int g = 0; g < 70 && f_m(m_t) != 59; g++) step("to_m59", 1'b0, 1'b1, 1'b0);
    hs = f_h(m_t);
    ss = f_s(m_t);
    step("m_wrap", 1'b0, 1'b1, 1'b0);
    chk("m_wrap.min",  o_min,  0);
    chk("m_wrap.hour", o_hour, hs);
    chk("m_wrap.sec",  o_sec,  ss);

    // 4: sec adjust coincident with a sec carry adds two and still carries
    for (int g = 0; g < 70 && f_s(m_t) != 59; g++) step("to_s59", 1'b0, 1'b0, 1'b1);
    for (int g = 0; g < 3000 && !(f_c(m_t) == 99 && m_phase == DIV - 1); g++)
      step("run99b", 1'b0, 1'b0, 1'b0);
    hs = int'(o_min);
    step("s_both", 1'b0, 1'b0, 1'b1);
    chk("s_both.sec", o_sec, 1);
    chk("s_both.cs",  o_cs,  0);
    chk("s_both.min", o_min, (hs + 1) % 60);

    // 5: i_hour held for three cycles from 22, tick spacing undisturbed
    for (int g = 0; g < 30 && f_h(m_t) != 22; g++) step("to_h22", 1'b1, 1'b0, 1'b0);
    step("h_hold", 1'b1, 1'b0, 1'b0);
    chk("h_hold.23", o_hour, 23);
    step("h_hold", 1'b1, 1'b0, 1'b0);
    chk("h_hold.0", o_hour, 0);
    step("h_hold", 1'b1, 1'b0, 1'b0);
    chk("h_hold.1", o_hour, 1);
    last = -1;
    gap_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      step("spacing", 1'b0, 1'b0, 1'b0);
      if (o_tick === 1'b1) begin
        if (last >= 0) begin
          chk("spacing.gap", c - last, 10);
          gap_cnt++;
        end
        last = c;
      end
    end
    chk("spacing.count", gap_cnt, 3);

    // Random adjust traffic
    repeat (400)
      step("rand", $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0);

    // 6: asynchronous reset between edges
    repeat (4) step("pre_async", 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk_all("async");
    repeat (2) step("async_hold", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    first_tick("rerelease");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
